// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline register chain.
//   occ_width() : bit width of the occupancy count for a given chain shape
//   SLOT_W      : width of a single slice's entry count (0, 1 or 2 entries)
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int SLOT_W = 2;

  // Enough bits to represent every count from 0 up to DEPTH*(SKID+1) inclusive.
  function automatic int occ_width(input int depth, input int skid);
    return $clog2(depth * (skid + 1) + 1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// -----------------------------------------------------------------------------
// pipe_slice
// One valid/ready register slice of the elastic pipeline.
//   SKID=1 : main + skid entry, in_ready comes straight from a flop.
//   SKID=0 : single entry, in_ready passes out_ready through combinationally.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   in_valid/ready   upstream handshake, in_data payload
//   out_valid/ready  downstream handshake, out_data payload of oldest entry
//   flush            synchronous clear of all valid bits (data kept)
//   level            number of valid entries held by this slice
// -----------------------------------------------------------------------------
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               SKID       = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              flush,
  output logic [SLOT_W-1:0] level
);

  if (SKID != 0) begin : g_skid
    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             drain;

    // A full skid entry is the only reason to refuse, so ready is a pure flop.
    assign accept = in_valid && !skid_valid;
    assign drain  = main_valid && out_ready;

    // NOTE: non-blocking assignments for all state, so every flop in the chain
    // samples the values that existed before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        // NOTE: the payload registers are reset too, so out_data is defined
        // (RESET_DATA) from reset onwards; flush leaves them untouched.
        main_data  <= RESET_DATA;
        skid_data  <= RESET_DATA;
      end else if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (skid_valid) begin
        // Skid full means no accept this cycle; only a drain can move data.
        if (drain) begin
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid || drain) begin
          main_data  <= in_data;
          main_valid <= 1'b1;
        end else begin
          skid_data  <= in_data;
          skid_valid <= 1'b1;
        end
      end else if (drain) begin
        main_valid <= 1'b0;
      end
    end

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign level     = SLOT_W'(main_valid) + SLOT_W'(skid_valid);

  end else begin : g_pass
    logic             main_valid;
    logic [WIDTH-1:0] main_data;

    // Same-cycle replace on a full entry is legal, hence the out_ready term.
    assign in_ready = !main_valid || out_ready;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        main_valid <= 1'b0;
        main_data  <= RESET_DATA;
      end else if (flush) begin
        main_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else if (out_ready) begin
        main_valid <= 1'b0;
      end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign level     = SLOT_W'(main_valid);
  end

endmodule

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// Parametrised elastic pipeline: DEPTH pipe_slice instances chained
// output-to-input, with back-pressure stall, synchronous flush and an
// occupancy count equal to the number of valid entries in the chain.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   in_valid/ready   upstream handshake, in_data payload
//   out_valid/ready  downstream handshake, out_data payload of oldest beat
//   flush            discards every beat in flight at the next posedge
//   occupancy        number of valid entries currently held
// -----------------------------------------------------------------------------
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 1,
  parameter int               SKID       = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH-1:0]                    out_data,
  input  logic                                flush,
  output logic [occ_width(DEPTH, SKID)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH, SKID);

  logic [SLOT_W-1:0] level [DEPTH];

  // Each slice owns its link signals; neighbours are reached by name so the
  // combinational ready chain (SKID=0) never loops through one shared vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    logic             sl_in_valid;
    logic             sl_in_ready;
    logic [WIDTH-1:0] sl_in_data;
    logic             sl_out_valid;
    logic             sl_out_ready;
    logic [WIDTH-1:0] sl_out_data;

    if (k == 0) begin : g_head
      assign sl_in_valid = in_valid;
      assign sl_in_data  = in_data;
    end else begin : g_link
      assign sl_in_valid = g_slice[k-1].sl_out_valid;
      assign sl_in_data  = g_slice[k-1].sl_out_data;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign sl_out_ready = out_ready;
    end else begin : g_fwd
      assign sl_out_ready = g_slice[k+1].sl_in_ready;
    end

    pipe_slice #(
      .WIDTH      (WIDTH),
      .SKID       (SKID),
      .RESET_DATA (RESET_DATA)
    ) u_slice (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (sl_in_valid),
      .in_ready  (sl_in_ready),
      .in_data   (sl_in_data),
      .out_valid (sl_out_valid),
      .out_ready (sl_out_ready),
      .out_data  (sl_out_data),
      .flush     (flush),
      .level     (level[k])
    );
  end

  assign in_ready  = g_slice[0].sl_in_ready;
  assign out_valid = g_slice[DEPTH-1].sl_out_valid;
  assign out_data  = g_slice[DEPTH-1].sl_out_data;

  // Sum of registered valid bits: exact in every cycle, zero right after
  // reset or flush.
  always_comb begin
    // NOTE: default assigned first, so the accumulation loop cannot infer a latch.
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(level[k]);
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage
// Three pipe_stage instances side by side:
//   dut 0 : DEPTH=3 SKID=1     dut 1 : DEPTH=2 SKID=1     dut 2 : DEPTH=2 SKID=0
// A FIFO-queue model of each chain (accepted beats not yet delivered) is
// checked against the DUT outputs on every falling edge; directed tests pin
// latency, stall depth, flush and reset behaviour with literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_stage;

  localparam int N = 3;
  localparam int DEP [N] = '{3, 2, 2};
  localparam int SKD [N] = '{1, 1, 0};

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic [31:0] in_data   [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [31:0] out_data  [N];
  logic        flush     [N];
  logic [2:0]  occ0;
  logic [2:0]  occ1;
  logic [1:0]  occ2;
  int          occ [N];

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(32), .DEPTH(3), .SKID(1), .RESET_DATA(32'h0)) u_d3s1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .flush(flush[0]), .occupancy(occ0)
  );

  pipe_stage #(.WIDTH(32), .DEPTH(2), .SKID(1), .RESET_DATA(32'h0)) u_d2s1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .flush(flush[1]), .occupancy(occ1)
  );

  pipe_stage #(.WIDTH(32), .DEPTH(2), .SKID(0), .RESET_DATA(32'h0)) u_d2s0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .flush(flush[2]), .occupancy(occ2)
  );

  always_comb begin
    occ[0] = int'(occ0);
    occ[1] = int'(occ1);
    occ[2] = int'(occ2);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: per chain, the queue of beats accepted and not yet delivered, plus
  // logs of accept / stall / emit events tagged with the clock-edge number.
  // ---------------------------------------------------------------------------
  beat_t       q     [N][$];
  logic [31:0] elog  [N][$];
  int          ecyc  [N][$];
  int          acyc  [N][$];
  int          scyc  [N][$];
  bit          hold      [N];
  logic [31:0] hold_data [N];
  beat_t       nb;
  int          cyc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        q[i].delete();
        hold[i] = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < N; i++) begin
        hold[i]      = out_valid[i] && !out_ready[i] && !flush[i];
        hold_data[i] = out_data[i];
        if (in_valid[i] && !in_ready[i]) scyc[i].push_back(cyc);
        if (out_valid[i] && out_ready[i]) begin
          elog[i].push_back(out_data[i]);
          ecyc[i].push_back(cyc);
          if (q[i].size() > 0) begin
            check($sformatf("latency_ge_depth_d%0d", i),
                  longint'((cyc - q[i][0].cyc) >= DEP[i]), 1);
            void'(q[i].pop_front());
          end
        end
        if (flush[i]) begin
          q[i].delete();
        end else if (in_valid[i] && in_ready[i]) begin
          nb.data = in_data[i];
          nb.cyc  = cyc;
          q[i].push_back(nb);
          acyc[i].push_back(cyc);
        end
      end
    end
  end

  // Compare process: outputs settle between edges, so check on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("occupancy_d%0d", i), occ[i], q[i].size());
        if (q[i].size() == 0) begin
          check($sformatf("empty_out_valid_d%0d", i), out_valid[i], 0);
          check($sformatf("empty_in_ready_d%0d", i), in_ready[i], 1);
        end
        if (out_valid[i] && q[i].size() > 0)
          check($sformatf("out_data_order_d%0d", i), out_data[i], q[i][0].data);
        if (hold[i]) begin
          check($sformatf("stall_hold_valid_d%0d", i), out_valid[i], 1);
          check($sformatf("stall_hold_data_d%0d", i), out_data[i], hold_data[i]);
        end
        if (q[i].size() == DEP[i] * (SKD[i] + 1))
          check($sformatf("full_in_ready_d%0d", i), in_ready[i],
                (SKD[i] != 0) ? 0 : longint'(out_ready[i]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed and random stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qget(input int i, input int k);
    return (ecyc[i].size() > k) ? int'(elog[i][k]) : -1;
  endfunction

  initial begin
    int s, ab, eb, sb, thr;

    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
      flush[i]     = 1'b0;
    end

    // Reset state.
    #3;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_in_ready_d%0d", i), in_ready[i], 1);
      check($sformatf("rst_out_valid_d%0d", i), out_valid[i], 0);
      check($sformatf("rst_occupancy_d%0d", i), occ[i], 0);
      check($sformatf("rst_out_data_d%0d", i), out_data[i], 0);
    end

    // Stream 1..8 through DEPTH=3 SKID=1 from the first edge after release.
    #9;
    reset        = 1'b1;
    s            = cyc;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'h1;
    repeat (16) begin
      tick();
      in_data[0]  = 32'(acyc[0].size() + 1);
      in_valid[0] = (acyc[0].size() < 8);
    end
    check("stream_first_accept_edge", (acyc[0].size() > 0) ? acyc[0][0] : -1, s + 1);
    check("stream_first_latency", (ecyc[0].size() > 0) ? ecyc[0][0] - s : -1, 4);
    check("stream_beats_out", ecyc[0].size(), 8);
    for (int k = 0; k < 8; k++) check($sformatf("stream_data_%0d", k), qget(0, k), k + 1);
    check("stream_back_to_back", (ecyc[0].size() == 8) ? ecyc[0][7] - ecyc[0][0] : -1, 7);
    check("stream_no_in_ready_drop", scyc[0].size(), 0);

    // Stall DEPTH=2 SKID=1: four beats then in_ready low.
    s  = cyc;
    ab = acyc[1].size();
    eb = elog[1].size();
    sb = scyc[1].size();
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 32'h10;
    repeat (8) begin
      tick();
      in_data[1] = 32'h10 + 32'(acyc[1].size() - ab);
    end
    check("skid_stall_accepted", acyc[1].size() - ab, 4);
    check("skid_stall_in_ready", in_ready[1], 0);
    check("skid_stall_occupancy", occ[1], 4);
    check("skid_stall_first_edge", (scyc[1].size() > sb) ? scyc[1][sb] : -1, s + 5);
    out_ready[1] = 1'b1;
    repeat (6) begin
      tick();
      in_data[1] = 32'h10 + 32'(acyc[1].size() - ab);
    end
    in_valid[1] = 1'b0;
    repeat (6) tick();
    for (int k = 0; k < 4; k++)
      check($sformatf("skid_drain_data_%0d", k), qget(1, eb + k), 32'h10 + k);
    check("skid_stream_resumed", longint'((acyc[1].size() - ab) > 4), 1);

    // Stall DEPTH=2 SKID=0: two beats, combinational ready recovery.
    s  = cyc;
    ab = acyc[2].size();
    eb = elog[2].size();
    sb = scyc[2].size();
    out_ready[2] = 1'b0;
    in_valid[2]  = 1'b1;
    in_data[2]   = 32'h20;
    repeat (6) begin
      tick();
      in_data[2] = 32'h20 + 32'(acyc[2].size() - ab);
    end
    check("pass_stall_accepted", acyc[2].size() - ab, 2);
    check("pass_stall_in_ready", in_ready[2], 0);
    check("pass_stall_occupancy", occ[2], 2);
    check("pass_stall_first_edge", (scyc[2].size() > sb) ? scyc[2][sb] : -1, s + 3);
    out_ready[2] = 1'b1;
    #1;
    check("pass_ready_same_cycle", in_ready[2], 1);
    repeat (6) begin
      tick();
      in_data[2] = 32'h20 + 32'(acyc[2].size() - ab);
    end
    in_valid[2] = 1'b0;
    repeat (6) tick();
    check("pass_drain_data_0", qget(2, eb), 32'h20);
    check("pass_drain_data_1", qget(2, eb + 1), 32'h21);

    // Flush with three beats in flight and 0xAA offered in the flush cycle.
    ab = acyc[0].size();
    eb = elog[0].size();
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'h30;
    repeat (3) begin
      tick();
      in_data[0] = 32'h30 + 32'(acyc[0].size() - ab);
    end
    check("flush_pre_accepted", acyc[0].size() - ab, 3);
    check("flush_pre_occupancy", occ[0], 3);
    in_data[0] = 32'hAA;
    flush[0]   = 1'b1;
    check("flush_in_ready_ungated", in_ready[0], 1);
    tick();
    flush[0]     = 1'b0;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    check("flush_occupancy", occ[0], 0);
    check("flush_out_valid", out_valid[0], 0);
    repeat (10) tick();
    check("flush_nothing_emitted", elog[0].size() - eb, 0);

    // Asynchronous reset with two beats held in DEPTH=2 SKID=0.
    out_ready[2] = 1'b0;
    in_valid[2]  = 1'b1;
    in_data[2]   = 32'h40;
    ab = acyc[2].size();
    repeat (3) begin
      tick();
      in_data[2] = 32'h40 + 32'(acyc[2].size() - ab);
    end
    in_valid[2] = 1'b0;
    check("arst_pre_occupancy", occ[2], 2);
    check("arst_pre_out_valid", out_valid[2], 1);
    check("arst_pre_out_data", out_data[2], 32'h40);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid[2], 0);
    check("arst_occupancy", occ[2], 0);
    check("arst_out_data", out_data[2], 0);
    check("arst_in_ready", in_ready[2], 1);
    #4;
    reset = 1'b1;

    // Random valid/ready/flush traffic with varying back-pressure.
    for (int blk = 0; blk < 10; blk++) begin
      thr = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
      repeat (1000) begin
        tick();
        for (int i = 0; i < N; i++) begin
          in_valid[i]  = ($urandom_range(0, 3) != 0);
          in_data[i]   = $urandom;
          out_ready[i] = ($urandom_range(0, 99) < thr);
          flush[i]     = ($urandom_range(0, 99) == 0);
        end
      end
    end
    tick();
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      flush[i]     = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (20) tick();
    for (int i = 0; i < N; i++) begin
      check($sformatf("final_occupancy_d%0d", i), occ[i], 0);
      check($sformatf("final_out_valid_d%0d", i), out_valid[i], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
- Parametrised, elastic pipeline register chain. Successor to the fixed per-stage registers between IF/ID/EX/MEM/WB.
- Carries a WIDTH-bit payload through DEPTH register slices using a valid/ready handshake.
- Provides stall by back-pressure, synchronous flush (bubble insertion) and an occupancy count.
- Sits between any two CPU stages, or between the core and memory-side logic.

Parameters:
- WIDTH, 32, payload width in bits (minimum 1).
- DEPTH, 1, number of chained register slices (minimum 1).
- SKID, 1, 1 = each slice has a 2-entry skid buffer with registered in_ready; 0 = single entry with combinational ready pass-through.
- RESET_DATA, 0, value loaded into every data register on reset.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset. Reset is asserted when low.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage accepts a beat this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts a beat; low = stall.
- out_data  output  WIDTH  payload of the oldest beat.
- flush  input  1  synchronous; discards all beats in flight.
- occupancy  output  $clog2(DEPTH*(SKID+1)+1)  number of valid entries held.

Behaviour:
- Handshake:
  - A beat transfers on the input side when in_valid && in_ready at posedge.
  - A beat transfers on the output side when out_valid && out_ready at posedge.
  - Data order is strictly FIFO. No beat is duplicated or dropped, except on flush.
- Reset (reset low, asynchronous):
  - All valid bits 0; all data registers = RESET_DATA; occupancy 0.
  - out_valid 0; out_data = RESET_DATA.
  - in_ready 1 for SKID=1. For SKID=0 it follows its equation (also 1).
- Reset release: the first beat can be accepted at the first posedge after reset goes high.
- Slice with SKID=1:
  - Entries main and skid. in_ready = !skid_valid, driven straight from a flop.
  - Accept with main empty, or main draining this cycle: load main.
  - Accept with main full and not draining: load skid.
  - Main drains while skid is full: main takes skid, skid clears.
  - Input-to-output latency is 1 cycle per slice; throughput is 1 beat/cycle sustained.
- Slice with SKID=0:
  - in_ready = !main_valid || out_ready (combinational).
  - Latency 1 cycle; throughput 1 beat/cycle.
- Chain: slice k's output feeds slice k+1's input. Minimum latency is DEPTH cycles.
- Stall: while out_ready is held low, out_valid/out_data stay stable until transfer. The chain fills, then in_ready falls:
  - SKID=1: in_ready falls after DEPTH*2 accepted beats.
  - SKID=0: in_ready falls after DEPTH beats.
- Flush:
  - Has priority over every other event.
  - At posedge with flush=1, all valid bits clear and occupancy goes to 0. A beat accepted or emitted in that same cycle is discarded; an output handshake in the flush cycle still counts as taken by the consumer.
  - Data registers are not cleared.
  - in_ready is not gated by flush.
- Simultaneous accept and emit on a full SKID=1 slice: this cannot occur because in_ready=0. On a full SKID=0 slice, the same-cycle replace is legal.
- occupancy = sum of all valid bits, registered, exact every cycle. It never exceeds DEPTH*(SKID+1).
- Reset asserted mid-transfer: state clears immediately and asynchronously. Beats in flight are lost.

Decomposition:
- Shared package pipe_pkg: localparam function for the occupancy width; a handshake struct type is not required.
- Natural sub-module: pipe_slice (WIDTH, SKID), a single slice. pipe_stage instantiates DEPTH of them in a generate loop and sums their valid bits.

Test Plan:
- Reset with WIDTH=32, RESET_DATA=0: hold reset low mid-run with 2 beats in flight. Required: out_valid=0, occupancy=0, out_data=0 asynchronously, before the next clk edge.
- DEPTH=3, SKID=1, out_ready=1, stream 0x1..0x8 back-to-back. Required: 0x1 appears on out_data 3 cycles after its accept, then one beat per cycle in order, with no in_ready deassertion.
- DEPTH=2, SKID=1, out_ready=0, in_valid held. Required: exactly 4 beats accepted, in_ready=0 from cycle 5, occupancy=4. Raising out_ready yields the 4 beats in order, then the stream resumes.
- DEPTH=2, SKID=0, same stall. Required: 2 beats accepted, in_ready drops combinationally, occupancy=2. The in_ready rise is seen in the same cycle out_ready rises.
- Flush with occupancy=3 while in_valid=1 and data 0xAA. Required: next cycle occupancy=0 and out_valid=0; 0xAA never appears at the output.
- Random valid/ready toggling for 10k cycles with a scoreboard. Required: in-order, lossless delivery, and occupancy always equal to the scoreboard depth.
